frec_selector: RTL and testbench
================================

Name: frec_selector

Overview:
- Operator front end for the frequency divider stage.
- Debounces two raw push-buttons (up/down) and steps through the eight supported frequency codes: 30, 50, 75, 100, 125, 150, 175, 200.
- Drives `frecnum[7:0]` directly into the divider's frequency input.
- Also provides BCD digits of the selected value for the 7-segment display path.

Parameters:
- DEB_CYCLES, 1000000, consecutive stable synchronized samples required before a button level is accepted (10 ms at 100 MHz); legal range 2..2^20.
- DEB_W, 20, width of the debounce counters; must hold DEB_CYCLES-1.

Ports:
- clk  in  1  system clock, same clock as the divider stage
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); released synchronously by board logic
- btn_up  in  1  raw, asynchronous push-button, 1 = pressed
- btn_down  in  1  raw, asynchronous push-button, 1 = pressed
- frecnum  out  8  selected frequency code (binary), feeds the divider
- sel_idx  out  3  index of the selection, 0 = 30 … 7 = 200
- freq_chg  out  1  one-cycle pulse when frecnum changes
- bcd_h  out  4  hundreds digit of frecnum
- bcd_t  out  4  tens digit of frecnum
- bcd_u  out  4  units digit of frecnum

Behaviour:
- Reset (`reset`=0, asynchronous) clears all state:
  - sync flops, debounced levels, debounce counters, delayed levels: 0
  - sel_idx = 0, frecnum = 30, bcd_h/t/u = 0/3/0, freq_chg = 0
- Synchronizer: each button passes through two flops, s1 then s2.
- Debounce, per button, with registered level db and counter cnt:
  - if s2 == db: cnt <= 0
  - else if cnt == DEB_CYCLES-1: db <= s2, cnt <= 0
  - else: cnt <= cnt+1
  - Any bounce back to db before acceptance restarts the count.
- Press detect: press = db & ~db_d, where db_d is db delayed one cycle. Release edges are ignored.
- Step rules, evaluated on the edge after press is seen:
  - up press only, sel_idx < 7: sel_idx+1, freq_chg = 1
  - down press only, sel_idx > 0: sel_idx-1, freq_chg = 1
  - up at index 7 or down at index 0: saturate, no change, freq_chg stays 0 (no wrap-around)
  - up and down press in the same cycle: both ignored, freq_chg = 0
  - holding a button yields exactly one step; there is no auto-repeat
- Table, index -> frecnum/bcd: 0->30, 1->50, 2->75, 3->100, 4->125, 5->150, 6->175, 7->200.
  - frecnum, sel_idx and bcd_* are registered and update on the same edge, so they are always mutually consistent.
  - frecnum is only ever one of the eight table values.
- freq_chg is high for exactly one cycle, coincident with the first cycle the new frecnum is visible.
- Latency: let edge 0 be the first clk edge at which btn is sampled 1, with btn held stable.
  - s2 = 1 after edge 1; db = 1 after edge DEB_CYCLES+1.
  - frecnum/sel_idx/bcd update and freq_chg rises after edge DEB_CYCLES+2.
  - freq_chg falls after edge DEB_CYCLES+3.
- Reset mid-operation: pending debounce progress is discarded. A button still held at reset release counts as a new press, with the full latency from the first sampling edge after release.

Test Plan:
1. Reset then idle, DEB_CYCLES=4 → frecnum=30, sel_idx=0, bcd=0/3/0, freq_chg=0 indefinitely.
2. Clean press on btn_up held 20 cycles, DEB_CYCLES=4 → after edge 6, frecnum=50, bcd=0/5/0, freq_chg high exactly one cycle; no further change while held or on release.
3. Seven separate up presses, then one more → frecnum sequence 50,75,100,125,150,175,200, then stays 200 with no freq_chg. Eight down presses → back to 30, last press gives no freq_chg.
4. Bouncy btn_up: pulses of 1–3 cycles separated by 1-cycle lows, DEB_CYCLES=4 → no change. Then hold stable → exactly one step.
5. btn_up and btn_down rising together, stable → both press pulses coincide, frecnum unchanged, no freq_chg. Staggered by 10 cycles → up then down steps, net unchanged, two freq_chg pulses.
6. Assert reset during debounce of btn_down at index 3 (frecnum=100) → outputs immediately 30/idx 0. Button held across release → frecnum remains 30 (saturated), freq_chg=0. Repeat with btn_up held → 50 after DEB_CYCLES+2 edges from release.

Source files
------------

// File: rtl/frec_selector.sv
// Operator front end for the frequency divider: debounces the up/down buttons and
// steps through the eight supported frequency codes, with matching BCD digits.
module frec_selector #(
   parameter int unsigned DEB_CYCLES = 1000000,
   parameter int unsigned DEB_W      = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [7:0] frecnum,
   output logic [2:0] sel_idx,
   output logic       freq_chg,
   output logic [3:0] bcd_h,
   output logic [3:0] bcd_t,
   output logic [3:0] bcd_u
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   // bit 0 = up button, bit 1 = down button
   logic [1:0]       s1;
   logic [1:0]       s2;
   logic [1:0]       db;
   logic [1:0]       db_d;
   logic [DEB_W-1:0] cnt [2];
   logic [1:0]       press;
   logic             step;
   logic [2:0]       next_idx;
   logic [19:0]      next_entry;

   function automatic logic [19:0] lut(input logic [2:0] idx);
      logic [19:0] e;
      case (idx)
         3'd0:    e = {8'd30,  4'd0, 4'd3, 4'd0};
         3'd1:    e = {8'd50,  4'd0, 4'd5, 4'd0};
         3'd2:    e = {8'd75,  4'd0, 4'd7, 4'd5};
         3'd3:    e = {8'd100, 4'd1, 4'd0, 4'd0};
         3'd4:    e = {8'd125, 4'd1, 4'd2, 4'd5};
         3'd5:    e = {8'd150, 4'd1, 4'd5, 4'd0};
         3'd6:    e = {8'd175, 4'd1, 4'd7, 4'd5};
         default: e = {8'd200, 4'd2, 4'd0, 4'd0};
      endcase
      return e;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1     <= '0;
         s2     <= '0;
         db     <= '0;
         db_d   <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         s1   <= {btn_down, btn_up};
         s2   <= s1;
         db_d <= db;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               db[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   assign press = db & ~db_d;

   // simultaneous presses cancel; saturate at both ends of the table
   always_comb begin
      step     = 1'b0;
      next_idx = sel_idx;
      if (press == 2'b01 && sel_idx != 3'd7) begin
         step     = 1'b1;
         next_idx = sel_idx + 3'd1;
      end else if (press == 2'b10 && sel_idx != 3'd0) begin
         step     = 1'b1;
         next_idx = sel_idx - 3'd1;
      end
   end

   assign next_entry = lut(next_idx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_idx  <= 3'd0;
         frecnum  <= 8'd30;
         bcd_h    <= 4'd0;
         bcd_t    <= 4'd3;
         bcd_u    <= 4'd0;
         freq_chg <= 1'b0;
      end else begin
         freq_chg <= step;
         if (step) begin
            sel_idx <= next_idx;
            {frecnum, bcd_h, bcd_t, bcd_u} <= next_entry;
         end
      end
   end

endmodule

// File: tb/tb_frec_selector.sv
// Bench for frec_selector: directed scenarios plus random button activity, checked
// every cycle against a sample-window model of the debounce and step rules.
module tb_frec_selector;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [7:0] frecnum;
   logic [2:0] sel_idx;
   logic       freq_chg;
   logic [3:0] bcd_h;
   logic [3:0] bcd_t;
   logic [3:0] bcd_u;

   int checks = 0;
   int failures = 0;
   int tbl [8] = '{30, 50, 75, 100, 125, 150, 175, 200};

   frec_selector #(.DEB_CYCLES(DEB), .DEB_W(4)) dut (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
      .frecnum(frecnum), .sel_idx(sel_idx), .freq_chg(freq_chg),
      .bcd_h(bcd_h), .bcd_t(bcd_t), .bcd_u(bcd_u)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a button level is accepted once the last DEB synchronized samples
   // (raw samples delayed two edges) all differ from the accepted level.
   int idx_m;
   bit chg_m;
   bit db_m [2];
   bit pend [2];
   bit qu[$];
   bit qd[$];

   function automatic bit flips(input bit qq[$], input bit lvl);
      bit all = 1'b1;
      for (int k = 1; k <= DEB; k++)
         if (qq[qq.size() - 1 - k] == lvl) all = 1'b0;
      return all;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_m = 0;
         chg_m = 1'b0;
         db_m[0] = 1'b0; db_m[1] = 1'b0;
         pend[0] = 1'b0; pend[1] = 1'b0;
         qu.delete(); qd.delete();
         for (int k = 0; k < DEB + 1; k++) begin
            qu.push_back(1'b0);
            qd.push_back(1'b0);
         end
      end else begin
         chg_m = 1'b0;
         if (pend[0] && !pend[1] && idx_m < 7) begin
            idx_m++; chg_m = 1'b1;
         end else if (pend[1] && !pend[0] && idx_m > 0) begin
            idx_m--; chg_m = 1'b1;
         end
         pend[0] = 1'b0; pend[1] = 1'b0;
         if (flips(qu, db_m[0])) begin db_m[0] = !db_m[0]; pend[0] = db_m[0]; end
         if (flips(qd, db_m[1])) begin db_m[1] = !db_m[1]; pend[1] = db_m[1]; end
         qu.push_back(btn_up);
         qd.push_back(btn_down);
         if (qu.size() > DEB + 2) void'(qu.pop_front());
         if (qd.size() > DEB + 2) void'(qd.pop_front());
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("frecnum", int'(frecnum), tbl[idx_m]);
         chk("sel_idx", int'(sel_idx), idx_m);
         chk("freq_chg", int'(freq_chg), int'(chg_m));
         chk("bcd_h", int'(bcd_h), tbl[idx_m] / 100);
         chk("bcd_t", int'(bcd_t), (tbl[idx_m] / 10) % 10);
         chk("bcd_u", int'(bcd_u), tbl[idx_m] % 10);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit up, input int hold);
      if (up) btn_up = 1'b1; else btn_down = 1'b1;
      tick(hold);
      btn_up = 1'b0; btn_down = 1'b0;
      tick(DEB + 6);
   endtask

   int pulses;

   initial begin
      // reset then idle
      tick(3);
      chk("rst_frecnum", int'(frecnum), 30);
      chk("rst_bcd", int'({bcd_h, bcd_t, bcd_u}), 'h030);
      reset = 1'b1;
      tick(12);
      chk("idle_frecnum", int'(frecnum), 30);
      chk("idle_chg", int'(freq_chg), 0);

      // clean press: update after edge DEB+2
      btn_up = 1'b1;
      tick(DEB + 2);
      chk("lat_before", int'(frecnum), 30);
      tick(1);
      chk("lat_frecnum", int'(frecnum), 50);
      chk("lat_chg_rise", int'(freq_chg), 1);
      chk("lat_bcd", int'({bcd_h, bcd_t, bcd_u}), 'h050);
      tick(1);
      chk("lat_chg_fall", int'(freq_chg), 0);
      tick(12);
      btn_up = 1'b0;
      tick(10);
      chk("held_once", int'(frecnum), 50);

      // walk to the top, saturate, walk down, saturate
      for (int i = 0; i < 6; i++) press(1'b1, 8);
      chk("top", int'(frecnum), 200);
      press(1'b1, 8);
      chk("top_sat", int'(frecnum), 200);
      for (int i = 0; i < 7; i++) press(1'b0, 8);
      chk("bottom", int'(frecnum), 30);
      press(1'b0, 8);
      chk("bottom_sat", int'(frecnum), 30);
      press(1'b1, 8);

      // bouncy up: runs of 1..3 highs never reach DEB
      for (int i = 0; i < 6; i++) begin
         btn_up = 1'b1; tick(1 + (i % 3));
         btn_up = 1'b0; tick(1);
      end
      tick(DEB + 4);
      chk("bounce_nochg", int'(frecnum), 50);
      press(1'b1, 10);
      chk("bounce_step", int'(frecnum), 75);
      press(1'b0, 10);

      // simultaneous presses cancel; staggered give up then down
      btn_up = 1'b1; btn_down = 1'b1;
      tick(12);
      btn_up = 1'b0; btn_down = 1'b0;
      tick(DEB + 6);
      chk("simul", int'(frecnum), 50);
      pulses = 0;
      btn_up = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 10) btn_down = 1'b1;
         tick(1);
         if (freq_chg) pulses++;
      end
      btn_up = 1'b0; btn_down = 1'b0;
      tick(DEB + 6);
      chk("stagger_pulses", pulses, 2);
      chk("stagger_net", int'(frecnum), 50);

      // reset in mid-debounce
      press(1'b1, 8);
      press(1'b1, 8);
      chk("idx3", int'(frecnum), 100);
      btn_down = 1'b1;
      tick(3);
      #1 reset = 1'b0;
      #1 chk("async_rst", int'(frecnum), 30);
      tick(2);
      reset = 1'b1;
      tick(DEB + 6);
      chk("held_down_sat", int'(frecnum), 30);
      btn_down = 1'b0;
      tick(DEB + 4);
      btn_up = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(DEB + 2);
      chk("held_up_before", int'(frecnum), 30);
      tick(1);
      chk("held_up_after", int'(frecnum), 50);
      btn_up = 1'b0;
      tick(DEB + 4);

      // random activity
      for (int i = 0; i < 500; i++) begin
         btn_up = ($urandom_range(0, 2) == 0);
         btn_down = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 60) == 0) begin
            reset = 1'b0;
            tick($urandom_range(1, 3));
            reset = 1'b1;
         end
         tick($urandom_range(1, 12));
      end
      btn_up = 1'b0; btn_down = 1'b0;
      tick(DEB + 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
